// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter and hazard scoreboard for the register file's single write port.
// Optional operand forwarding from the write slot is enabled by defining REGWB_FORWARD_EN.
module reg_wb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int FIX_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSYWAIT,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              M_VALID,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_DATA,
  output logic              M_READY,
  input  logic              ISSUE_VALID,
  input  logic [ADDR_W-1:0] ISSUE_ADDR,
  input  logic              RD_EN1,
  input  logic              RD_EN2,
  input  logic [ADDR_W-1:0] RD_ADDR1,
  input  logic [ADDR_W-1:0] RD_ADDR2,
  output logic              STALL,
  output logic              WRITEEN,
  output logic [ADDR_W-1:0] INADDR,
  output logic [DATA_W-1:0] IN,
  output logic              FWD1,
  output logic              FWD2,
  output logic [DATA_W-1:0] FWD_DATA
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {SRC_A = 1'b0, SRC_M = 1'b1} src_e;

  src_e              last_q, last_d;
  logic              writeen_q, writeen_d;
  logic [ADDR_W-1:0] inaddr_q, inaddr_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic consume;
  logic grant_a, grant_m;
  logic issue_acc;
  logic fwd1, fwd2;
  logic [DATA_W-1:0] fwd_data;

  // The slot drains whenever the register file is not stalled, so with
  // BUSYWAIT low the slot is always free to take a new grant.
  assign consume = writeen_q & ~BUSYWAIT;

  // Handshake: a source holds VALID/ADDR/DATA stable until it sees READY high;
  // the transfer happens at the rising edge where VALID and READY are both 1.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!BUSYWAIT) begin
      if (A_VALID && !M_VALID) begin
        grant_a = 1'b1;
      end else if (M_VALID && !A_VALID) begin
        grant_m = 1'b1;
      end else if (A_VALID && M_VALID) begin
        if (FIX_PRIO != 0) begin
          grant_m = 1'b1;
        end else if (last_q == SRC_M) begin
          grant_a = 1'b1;
        end else begin
          grant_m = 1'b1;
        end
      end
    end
  end

  assign A_READY = grant_a;
  assign M_READY = grant_m;

`ifdef REGWB_FORWARD_EN
  assign fwd1     = writeen_q & RD_EN1 & (RD_ADDR1 == inaddr_q);
  assign fwd2     = writeen_q & RD_EN2 & (RD_ADDR2 == inaddr_q);
  assign fwd_data = in_q;
`else
  assign fwd1     = 1'b0;
  assign fwd2     = 1'b0;
  assign fwd_data = '0;
`endif

  // A forwarded operand no longer needs to wait; the issue term always does.
  assign STALL = (RD_EN1 & pend_q[RD_ADDR1] & ~fwd1)
               | (RD_EN2 & pend_q[RD_ADDR2] & ~fwd2)
               | (ISSUE_VALID & pend_q[ISSUE_ADDR]);

  assign issue_acc = ISSUE_VALID & ~STALL & ~BUSYWAIT;

  always_comb begin
    writeen_d = writeen_q;
    inaddr_d  = inaddr_q;
    in_d      = in_q;
    last_d    = last_q;
    if (grant_a) begin
      writeen_d = 1'b1;
      inaddr_d  = A_ADDR;
      in_d      = A_DATA;
      last_d    = SRC_A;
    end else if (grant_m) begin
      writeen_d = 1'b1;
      inaddr_d  = M_ADDR;
      in_d      = M_DATA;
      last_d    = SRC_M;
    end else if (consume) begin
      writeen_d = 1'b0;
    end
  end

  // Set is applied after clear so a same-edge issue to the retiring register wins.
  always_comb begin
    pend_d = pend_q;
    if (consume) pend_d[inaddr_q] = 1'b0;
    if (issue_acc) pend_d[ISSUE_ADDR] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      writeen_q <= 1'b0;
      inaddr_q  <= '0;
      in_q      <= '0;
      last_q    <= SRC_M;
      pend_q    <= '0;
    end else begin
      writeen_q <= writeen_d;
      inaddr_q  <= inaddr_d;
      in_q      <= in_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
    end
  end

  assign WRITEEN  = writeen_q;
  assign INADDR   = inaddr_q;
  assign IN       = in_q;
  assign FWD1     = fwd1;
  assign FWD2     = fwd2;
  assign FWD_DATA = fwd_data;

endmodule
